muldiv_unit: RTL
================

Name: muldiv_unit

Overview:
- Iterative multiply/divide unit holding architectural HI/LO registers.
- Serves mult, multu, div, divu, mfhi, mflo, mthi and mtlo for the MIPS datapath, alongside the combinational ALU.
- Parametrised in operand width.
- Uses one shift/add or shift/subtract step per cycle, so the datapath must stall on busy.

Parameters:
- WIDTH, 32, operand width; hi/lo are each WIDTH bits. Minimum 4.
- CNT_W, $clog2(WIDTH)+1, iteration counter width (derived, do not override).

Ports:
- clk  in  1  system clock, all state updates on posedge.
- reset  in  1  synchronous, active-high.
- start  in  1  request an operation; sampled only when busy=0.
- op  in  2  operation: 00 mult, 01 multu, 10 div, 11 divu.
- a  in  WIDTH  multiplicand or dividend (rs).
- b  in  WIDTH  multiplier or divisor (rt).
- hi_we  in  1  mthi: load hi from wdata; honoured only when busy=0.
- lo_we  in  1  mtlo: load lo from wdata; honoured only when busy=0.
- wdata  in  WIDTH  data for mthi/mtlo.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse; hi/lo hold the new result.
- div_by_zero  out  1  valid with done; 1 when a div/divu had b=0.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset).
- Reset values: hi=0, lo=0, busy=0, done=0, div_by_zero=0, state=IDLE.
- Reset mid-operation aborts the operation with no done pulse.
- FSM states: IDLE, RUN, FINISH.
- IDLE:
  - start=1 at edge E0 latches |a|, |b| (signed ops take two's-complement magnitude; unsigned ops use the raw value), the result signs and op.
  - Counter cleared, go to RUN; busy=1 from E0.
  - hi_we/lo_we are ignored in the cycle start is accepted.
- RUN:
  - One iteration per edge, E1..E(WIDTH), then go to FINISH.
  - Multiply: shift-add; 2*WIDTH-bit product accumulator.
  - Divide: restoring; one quotient bit per cycle, MSB first; the remainder register is WIDTH+1 bits.
- FINISH:
  - On edge E(WIDTH+1), apply sign correction and write hi/lo.
  - Same edge: busy=0, done=1 (one cycle), return to IDLE.
  - Total latency is WIDTH+1 cycles from the start edge to a visible result.
- Result mapping:
  - mult/multu: {hi,lo} = full 2*WIDTH-bit product.
  - Signed product sign = a[MSB]^b[MSB]; negate the full 2*WIDTH value.
  - div/divu: lo = quotient, hi = remainder.
  - Signed quotient truncates toward zero; remainder takes the sign of the dividend.
- Boundary: divide by zero (b=0):
  - Divide still runs the full WIDTH cycles (fixed latency).
  - Result lo = all ones, hi = a unmodified, div_by_zero=1 with done.
- Boundary: signed overflow (div of the most negative value by -1): lo = most negative value, hi=0, div_by_zero=0.
- busy=1 behaviour:
  - start ignored.
  - hi_we/lo_we ignored.
  - a/b/op changes have no effect (operands are latched).
- start in the same cycle done=1 is accepted (busy already 0); back-to-back issue gives a result every WIDTH+1 cycles.
- hi_we and lo_we may both be 1 in the same idle cycle; both registers load wdata.
- hi/lo are otherwise stable; they never change during RUN.
- done and div_by_zero are 0 in all cycles other than FINISH.

Test Plan (WIDTH=32):
1. mult a=FFFFFFFD (-3), b=7 -> after 33 cycles: done pulse, hi=FFFFFFFF, lo=FFFFFFEB; busy high exactly 33 cycles. multu a=FFFFFFFF, b=FFFFFFFF -> hi=FFFFFFFE, lo=00000001.
2. div a=FFFFFFF9 (-7), b=2 -> lo=FFFFFFFD, hi=FFFFFFFF. divu a=7, b=2 -> lo=3, hi=1. div a=80000000, b=FFFFFFFF -> lo=80000000, hi=0, div_by_zero=0.
3. divu a=00000064, b=0 -> done after 33 cycles: hi=00000064, lo=FFFFFFFF, div_by_zero=1. Next op (mult 2*3) -> div_by_zero=0, lo=6, hi=0.
4. mult 5*6 started; at cycle 10 pulse start with div 9/3, hi_we=1, wdata=AAAA5555 -> all ignored. Final hi=0, lo=1E; exactly one done pulse.
5. Reset asserted at cycle 12 of a mult -> next edge: busy=0, hi=lo=0, no done. A fresh mult 2*2 then completes normally (lo=4).
6. mthi/mtlo with hi_we=1, lo_we=1, wdata=12345678 while idle -> hi=lo=12345678 next edge. start asserted in the done cycle of a prior op -> new op accepted; second done exactly 33 cycles later.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// One shift/add (multiply) or restoring shift/subtract (divide) step per cycle.
module muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

    // Two's-complement magnitude of a signed operand; unsigned operands pass through.
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic is_signed);
        mag = (is_signed && v[WIDTH-1]) ? (~v + {{(WIDTH-1){1'b0}}, 1'b1}) : v;
    endfunction

    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
        neg_w = ~v + {{(WIDTH-1){1'b0}}, 1'b1};
    endfunction

    function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v);
        neg_2w = ~v + {{(2*WIDTH-1){1'b0}}, 1'b1};
    endfunction

    state_t               state_r;
    state_t               state_s;
    logic [CNT_W-1:0]     cnt_r;
    logic                 is_div_r;
    logic                 neg_q_r;
    logic                 neg_r_r;
    logic                 b_zero_r;
    logic [WIDTH-1:0]     a_raw_r;
    logic [WIDTH-1:0]     opd_r;
    logic [2*WIDTH-1:0]   acc_r;
    logic [WIDTH:0]       rem_r;
    logic                 busy_r;
    logic                 done_r;
    logic                 dbz_r;
    logic [WIDTH-1:0]     hi_r;
    logic [WIDTH-1:0]     lo_r;

    logic                 busy_s;
    logic                 done_s;
    logic                 dbz_s;
    logic [WIDTH-1:0]     hi_s;
    logic [WIDTH-1:0]     lo_s;
    logic [WIDTH:0]       add_s;
    logic [WIDTH+1:0]     diff_s;
    logic                 fits_s;
    logic                 last_s;
    logic                 sgn_op_s;

    assign sgn_op_s = ~op[0];
    assign last_s   = (cnt_r == CNT_W'(WIDTH - 1));

    // Multiply step adds the multiplicand into the upper half when the current multiplier bit is set.
    assign add_s  = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + (acc_r[0] ? {1'b0, opd_r} : {(WIDTH+1){1'b0}});
    // Divide step trial-subtracts the divisor from 2*rem + next dividend bit; a clear top bit means it fits.
    assign diff_s = {rem_r, acc_r[WIDTH-1]} - {2'b00, opd_r};
    assign fits_s = ~diff_s[WIDTH+1];

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE:    state_s = start ? RUN : IDLE;
            RUN:     state_s = last_s ? FINISH : RUN;
            FINISH:  state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Output logic: next values of the visible registers, including sign correction at FINISH.
    always_comb begin
        busy_s = (state_s != IDLE);
        done_s = 1'b0;
        dbz_s  = 1'b0;
        hi_s   = hi_r;
        lo_s   = lo_r;
        case (state_r)
            IDLE: begin
                if (!start) begin
                    if (hi_we) begin
                        hi_s = wdata;
                    end else begin
                        hi_s = hi_r;
                    end
                    if (lo_we) begin
                        lo_s = wdata;
                    end else begin
                        lo_s = lo_r;
                    end
                end else begin
                    hi_s = hi_r;
                    lo_s = lo_r;
                end
            end
            FINISH: begin
                done_s = 1'b1;
                if (!is_div_r) begin
                    {hi_s, lo_s} = neg_q_r ? neg_2w(acc_r) : acc_r;
                end else if (b_zero_r) begin
                    dbz_s = 1'b1;
                    hi_s  = a_raw_r;
                    lo_s  = {WIDTH{1'b1}};
                end else begin
                    lo_s = neg_q_r ? neg_w(acc_r[WIDTH-1:0]) : acc_r[WIDTH-1:0];
                    hi_s = neg_r_r ? neg_w(rem_r[WIDTH-1:0]) : rem_r[WIDTH-1:0];
                end
            end
            default: begin
                hi_s = hi_r;
                lo_s = lo_r;
            end
        endcase
    end

    // Registered outputs and iterative datapath.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            dbz_r    <= 1'b0;
            hi_r     <= {WIDTH{1'b0}};
            lo_r     <= {WIDTH{1'b0}};
            cnt_r    <= {CNT_W{1'b0}};
            is_div_r <= 1'b0;
            neg_q_r  <= 1'b0;
            neg_r_r  <= 1'b0;
            b_zero_r <= 1'b0;
            a_raw_r  <= {WIDTH{1'b0}};
            opd_r    <= {WIDTH{1'b0}};
            acc_r    <= {(2*WIDTH){1'b0}};
            rem_r    <= {(WIDTH+1){1'b0}};
        end else begin
            busy_r <= busy_s;
            done_r <= done_s;
            dbz_r  <= dbz_s;
            hi_r   <= hi_s;
            lo_r   <= lo_s;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        cnt_r    <= {CNT_W{1'b0}};
                        is_div_r <= op[1];
                        neg_q_r  <= sgn_op_s & (a[WIDTH-1] ^ b[WIDTH-1]);
                        neg_r_r  <= sgn_op_s & a[WIDTH-1];
                        b_zero_r <= (b == {WIDTH{1'b0}});
                        a_raw_r  <= a;
                        rem_r    <= {(WIDTH+1){1'b0}};
                        // Multiply: opd = |a|, acc low = |b|. Divide: opd = |b|, acc low = |a|.
                        if (op[1]) begin
                            opd_r <= mag(b, sgn_op_s);
                            acc_r <= {{WIDTH{1'b0}}, mag(a, sgn_op_s)};
                        end else begin
                            opd_r <= mag(a, sgn_op_s);
                            acc_r <= {{WIDTH{1'b0}}, mag(b, sgn_op_s)};
                        end
                    end
                end
                RUN: begin
                    cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    if (is_div_r) begin
                        acc_r[WIDTH-1:0] <= {acc_r[WIDTH-2:0], fits_s};
                        if (fits_s) begin
                            rem_r <= diff_s[WIDTH:0];
                        end else begin
                            rem_r <= {rem_r[WIDTH-1:0], acc_r[WIDTH-1]};
                        end
                    end else begin
                        acc_r <= {add_s, acc_r[WIDTH-1:1]};
                    end
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

    assign busy        = busy_r;
    assign done        = done_r;
    assign div_by_zero = dbz_r;
    assign hi          = hi_r;
    assign lo          = lo_r;

endmodule
